// File: rtl/mpu_pkg.sv
// Shared types and constants for the 5x5 element-wise matrix add controller.
package mpu_pkg;
    localparam int MPU_DW    = 8;
    localparam int MPU_IW    = 5;
    localparam int MPU_N     = 5;
    localparam int MPU_ELEMS = MPU_N * MPU_N;
    localparam int MPU_EW    = MPU_IW + MPU_DW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } mpu_state_e;
endpackage

// File: rtl/mpu_result_fifo.sv
// Small result FIFO; head is presented combinationally, count feeds the read credit.
module mpu_result_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 13
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];
    assign do_pop = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mpu_add_controller.sv
// Element-wise add of two 5x5 byte matrices: credit-limited operand reads, result FIFO to the sink.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing operand reads, results flowing out
// ST_DRAIN | all reads issued, waiting for the last write
// ST_DONE  | one-cycle done pulse
module mpu_add_controller
    import mpu_pkg::*;
#(
    parameter bit SATURATE = 1'b0,
    parameter int N        = MPU_N
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [MPU_IW-1:0] rd_addr,
    input  logic [MPU_DW-1:0] a_data,
    input  logic [MPU_DW-1:0] b_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [MPU_IW-1:0] wr_addr,
    output logic [MPU_DW-1:0] wr_data,
    output logic              overflow
);
    localparam int              ELEMS = N * N;
    localparam logic [MPU_IW-1:0] LAST = MPU_IW'(ELEMS - 1);

    mpu_state_e        state, state_nxt;
    logic [MPU_IW-1:0] rd_cnt, wr_cnt;
    logic              inflight_q;
    logic [MPU_IW-1:0] inflight_idx_q;
    logic              ovf_q;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [MPU_EW-1:0] fifo_head;
    logic [MPU_DW:0]   sum9;
    logic [MPU_DW-1:0] result;
    logic              start_acc, pop, credit_ok;

    assign start_acc = (state == ST_IDLE) && start;
    assign sum9      = {1'b0, a_data} + {1'b0, b_data};
    assign result    = (SATURATE && sum9[MPU_DW]) ? {MPU_DW{1'b1}} : sum9[MPU_DW-1:0];
    // Occupancy plus the read whose data is still on its way must leave a free slot.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd3;

    assign rd_en    = (state == ST_RUN) && credit_ok;
    assign rd_addr  = rd_cnt;
    assign wr_valid = !fifo_empty;
    assign wr_addr  = fifo_head[MPU_EW-1:MPU_DW];
    assign wr_data  = fifo_head[MPU_DW-1:0];
    assign pop      = wr_valid && wr_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign overflow = ovf_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (rd_en && rd_cnt == LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && wr_cnt == LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state          <= state_nxt;
            inflight_q     <= rd_en;
            inflight_idx_q <= rd_cnt;
            if (start_acc) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (pop)   wr_cnt <= wr_cnt + 1'b1;
                if (inflight_q && sum9[MPU_DW]) ovf_q <= 1'b1;
            end
        end
    end

    mpu_result_fifo #(
        .DEPTH(3),
        .WIDTH(MPU_EW)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (inflight_q),
        .push_data({inflight_idx_q, result}),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_mpu_add_controller.sv
// Directed bench for mpu_add_controller: wrap and saturating instances share one operand store.
module tb_mpu_add_controller;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       wr_ready;
    logic [7:0] a_data, b_data;

    logic       busy, done, rd_en, wr_valid, overflow;
    logic [4:0] rd_addr, wr_addr;
    logic [7:0] wr_data;
    logic       busy_s, done_s, rd_en_s, wr_valid_s, overflow_s;
    logic [4:0] rd_addr_s, wr_addr_s;
    logic [7:0] wr_data_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem_a [25];
    logic [7:0] mem_b [25];

    mpu_add_controller #(.SATURATE(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .overflow(overflow)
    );

    mpu_add_controller #(.SATURATE(1'b1)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .a_data(a_data), .b_data(b_data),
        .wr_valid(wr_valid_s), .wr_ready(wr_ready), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .overflow(overflow_s)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Operand storage with one cycle read latency.
    always @(posedge clock) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    int         exp_idx, issued, accepted, op_writes, first_wv, done_cyc, done_cnt;
    int         busy_rises, t_start;
    logic       prev_busy, stall_q;
    logic [4:0] stall_addr;
    logic [7:0] stall_data;
    logic [7:0] last_wd, last_ws, wd7, ws7;
    logic [8:0] s9;
    logic [7:0] m_wrap, m_sat;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_idx   = 0;
            issued    = 0;
            accepted  = 0;
            stall_q   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (start && !busy) begin
                exp_idx = 0; issued = 0; accepted = 0; op_writes = 0;
                first_wv = -1; done_cyc = -1; done_cnt = 0; busy_rises = 0;
                t_start = cyc;
            end
            if (rd_en) begin
                check("credit", 32'(issued - accepted < 3), 32'd1);
                check("rd_addr", 32'(rd_addr), 32'(issued));
                issued++;
            end
            if (stall_q) begin
                check("stall_valid", 32'(wr_valid), 32'd1);
                check("stall_addr", 32'(wr_addr), 32'(stall_addr));
                check("stall_data", 32'(wr_data), 32'(stall_data));
            end
            if (wr_valid && first_wv < 0) first_wv = cyc;
            if (wr_valid && wr_ready) begin
                if (exp_idx < 25) begin
                    s9     = {1'b0, mem_a[exp_idx]} + {1'b0, mem_b[exp_idx]};
                    m_wrap = s9[7:0];
                    m_sat  = s9[8] ? 8'hFF : s9[7:0];
                end else begin
                    m_wrap = 8'hxx;
                    m_sat  = 8'hxx;
                end
                check("wr_addr", 32'(wr_addr), 32'(exp_idx));
                check("wr_data", 32'(wr_data), 32'(m_wrap));
                check("sat_valid", 32'(wr_valid_s), 32'd1);
                check("sat_addr", 32'(wr_addr_s), 32'(exp_idx));
                check("sat_data", 32'(wr_data_s), 32'(m_sat));
                last_wd = wr_data;
                last_ws = wr_data_s;
                if (exp_idx == 7) begin wd7 = wr_data; ws7 = wr_data_s; end
                exp_idx++;
                op_writes++;
                accepted++;
            end
            stall_q    = wr_valid && !wr_ready;
            stall_addr = wr_addr;
            stall_data = wr_data;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy && !prev_busy) busy_rises++;
            prev_busy = busy;
        end
    end

    logic ovf_run1;

    task automatic run_op(input bit toggle_ready, input bit spam);
        bit seen_done;
        int k;
        seen_done = 1'b0;
        @(posedge clock); #1;
        start    = 1'b1;
        wr_ready = 1'b1;
        k = 1;
        while (1) begin
            @(posedge clock); #1;
            if (k == 1) ovf_run1 = overflow;
            if (seen_done) begin start = 1'b0; break; end
            if (k > 400) begin
                check("timeout", 32'd0, 32'd1);
                start = 1'b0;
                break;
            end
            start    = spam;
            wr_ready = toggle_ready ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            if (done) seen_done = 1'b1;
            k++;
        end
        wr_ready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_rd_en"}, 32'(rd_en),    32'd0);
        check({tag, "_rdadr"}, 32'(rd_addr),  32'd0);
        check({tag, "_wrval"}, 32'(wr_valid), 32'd0);
        check({tag, "_wradr"}, 32'(wr_addr),  32'd0);
        check({tag, "_wrdat"}, 32'(wr_data),  32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'(i); mem_b[i] = 8'(2 * i); end
        #1;
        check_outputs_zero("rst");
        check("rst_sat_wrval", 32'(wr_valid_s), 32'd0);
        check("rst_sat_ovf", 32'(overflow_s), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // A=i, B=2i, sink always ready
        run_op(1'b0, 1'b0);
        check("basic_first_wv", 32'(first_wv - t_start), 32'd3);
        check("basic_done_lat", 32'(done_cyc - t_start), 32'd28);
        check("basic_writes", 32'(op_writes), 32'd25);
        check("basic_last", 32'(last_wd), 32'd72);
        check("basic_ovf", 32'(overflow), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);

        // all carries: wrap gives 44, saturate gives 255
        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'd200; mem_b[i] = 8'd100; end
        run_op(1'b0, 1'b0);
        check("carry_writes", 32'(op_writes), 32'd25);
        check("carry_wrap", 32'(last_wd), 32'd44);
        check("carry_sat", 32'(last_ws), 32'd255);
        check("carry_ovf", 32'(overflow), 32'd1);
        check("carry_ovf_s", 32'(overflow_s), 32'd1);

        // single carry at index 7, then a clean op
        for (int i = 0; i < 25; i++) begin mem_a[i] = 8'(i); mem_b[i] = 8'(2 * i); end
        mem_a[7] = 8'd255; mem_b[7] = 8'd1;
        run_op(1'b0, 1'b0);
        check("one_ovf_cleared", 32'(ovf_run1), 32'd0);
        check("one_ovf", 32'(overflow), 32'd1);
        check("one_wd7", 32'(wd7), 32'd0);
        check("one_ws7", 32'(ws7), 32'd255);
        mem_a[7] = 8'd7; mem_b[7] = 8'd14;
        run_op(1'b0, 1'b0);
        check("clean_ovf_at_start", 32'(ovf_run1), 32'd0);
        check("clean_ovf", 32'(overflow), 32'd0);
        check("clean_ovf_s", 32'(overflow_s), 32'd0);
        check("clean_wd7", 32'(wd7), 32'd21);

        // sink ready pattern 1,0,0,1
        run_op(1'b1, 1'b0);
        check("stall_writes", 32'(op_writes), 32'd25);
        check("stall_next", 32'(exp_idx), 32'd25);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);

        // start held high throughout the operation
        run_op(1'b0, 1'b1);
        check("spam_writes", 32'(op_writes), 32'd25);
        check("spam_done_cnt", 32'(done_cnt), 32'd1);
        check("spam_busy_rises", 32'(busy_rises), 32'd1);
        repeat (3) @(posedge clock);
        #1 check("spam_idle", 32'(busy), 32'd0);

        // abort with reset after index 12 is written
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int k = 0; k < 100 && op_writes < 13; k++) begin
            @(posedge clock); #1;
        end
        check("abort_reached", 32'(op_writes), 32'd13);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("abort");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(1'b0, 1'b0);
        check("rerun_writes", 32'(op_writes), 32'd25);
        check("rerun_first_wv", 32'(first_wv - t_start), 32'd3);
        check("rerun_done_cnt", 32'(done_cnt), 32'd1);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
